// File: rtl/imem_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// imem_fetch_sequencer
//
// Owns the fetch PC and the single port of the instruction memory (combinational
// read, synchronous write). Sequences IF-stage fetch through four states:
// IDLE (core held), RUN (fetching), LOAD (program loader owns the port) and
// FAULT (fetch PC left the legal window or was misaligned; only reset exits).
//
// Legal window: [RESET_PC, RESET_PC + 4*DEPTH_WORDS), word aligned.
//
// Ports:
//   i_clk              rising-edge clock
//   i_reset            synchronous, active-high reset
//   i_start            pulse, IDLE -> RUN
//   i_stall            hold PC (IF/ID hazard)
//   i_redirect_valid   branch/jump taken, overrides stall
//   i_redirect_pc      redirect target
//   i_ld_req           loader requests port ownership (level)
//   i_ld_valid         loader write beat valid
//   i_ld_addr          loader write byte address
//   i_ld_data          loader write data
//   o_ld_ready         loader beat accepted this cycle
//   o_ld_err           one-cycle pulse after a dropped (bad address) beat
//   o_imem_addr        byte address to memory
//   o_imem_we          memory write enable
//   o_imem_wdata       memory write data
//   o_pc_out           PC of the instruction on the memory read data
//   o_inst_valid       memory read data is a valid fetched instruction
//   o_fault            sticky fetch fault
//   o_fetch_count      instructions issued since reset (wraps mod 2^32)
// -----------------------------------------------------------------------------
module imem_fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter int unsigned DEPTH_WORDS = 2048
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_ld_req,
    input  logic        i_ld_valid,
    input  logic [31:0] i_ld_addr,
    input  logic [31:0] i_ld_data,
    output logic        o_ld_ready,
    output logic        o_ld_err,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_we,
    output logic [31:0] o_imem_wdata,
    output logic [31:0] o_pc_out,
    output logic        o_inst_valid,
    output logic        o_fault,
    output logic [31:0] o_fetch_count
);

    localparam logic [31:0] WINDOW_BYTES = 32'(4 * DEPTH_WORDS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_count;
    logic        r_ld_err;

    logic [1:0]  w_state_next;
    logic [31:0] w_pc_next;
    logic [31:0] w_fetch_count_next;
    logic        w_ld_err_next;

    // -------------------------------------------------------------------------
    // Address checks
    // -------------------------------------------------------------------------
    logic [31:0] w_pc_seq;
    logic [31:0] w_pc_offset;
    logic        w_pc_seq_ok;
    logic [31:0] w_ld_offset;
    logic        w_ld_addr_ok;
    logic        w_in_load;
    logic        w_in_run;
    logic        w_in_fault;

    assign w_in_load  = (r_state == ST_LOAD);
    assign w_in_run   = (r_state == ST_RUN);
    assign w_in_fault = (r_state == ST_FAULT);

    // Candidate PC for the next RUN cycle: redirect beats stall beats increment.
    always_comb begin
        if (i_redirect_valid) begin
            w_pc_seq = i_redirect_pc;
        end else if (i_stall) begin
            w_pc_seq = r_pc;
        end else begin
            w_pc_seq = r_pc + 32'd4;
        end
    end

    // Unsigned subtract: addresses below RESET_PC wrap high and fail the compare,
    // and PC+4 wrapping past 0xFFFF_FFFC lands at 0 which also fails.
    assign w_pc_offset  = w_pc_seq - RESET_PC;
    assign w_pc_seq_ok  = (w_pc_offset < WINDOW_BYTES) && (w_pc_seq[1:0] == 2'b00);

    assign w_ld_offset  = i_ld_addr - RESET_PC;
    assign w_ld_addr_ok = (w_ld_offset < WINDOW_BYTES) && (i_ld_addr[1:0] == 2'b00);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_fetch_count_next = r_fetch_count;
        w_ld_err_next      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_ld_req) begin
                    w_state_next = ST_LOAD;
                end else if (i_start) begin
                    w_state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                w_pc_next = w_pc_seq;
                // A redirect issues a fetch even when stall is also raised.
                if (i_redirect_valid || !i_stall) begin
                    w_fetch_count_next = r_fetch_count + 32'd1;
                end
                // Loader takes precedence: the LOAD exit restarts at RESET_PC, so
                // whatever lands in r_pc here is discarded.
                if (i_ld_req) begin
                    w_state_next = ST_LOAD;
                end else if (!w_pc_seq_ok) begin
                    w_state_next = ST_FAULT;
                end
            end

            ST_LOAD: begin
                // Bad beats are consumed but flagged one cycle later.
                w_ld_err_next = i_ld_valid && !w_ld_addr_ok;
                if (!i_ld_req) begin
                    w_state_next = ST_IDLE;
                    w_pc_next    = RESET_PC;
                end
            end

            ST_FAULT: begin
                // Sticky until reset; everything else is ignored.
                w_state_next = ST_FAULT;
            end

            default: begin
                w_state_next = ST_IDLE;
                w_pc_next    = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_fetch_count <= 32'd0;
            r_ld_err      <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_fetch_count <= w_fetch_count_next;
            r_ld_err      <= w_ld_err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Control outputs are gated by reset so a beat in flight when reset is
    // asserted never reaches the memory.
    always_comb begin
        o_imem_addr  = w_in_load ? i_ld_addr : r_pc;
        o_imem_wdata = i_ld_data;
        o_inst_valid = 1'b0;
        o_ld_ready   = 1'b0;
        o_imem_we    = 1'b0;
        if (!i_reset) begin
            o_inst_valid = w_in_run;
            o_ld_ready   = w_in_load;
            o_imem_we    = w_in_load && i_ld_valid && w_ld_addr_ok;
        end
    end

    assign o_pc_out      = r_pc;
    assign o_fault       = w_in_fault && !i_reset;
    assign o_ld_err      = r_ld_err && !i_reset;
    assign o_fetch_count = r_fetch_count;

endmodule

// File: doc/imem_fetch_sequencer.md
Name: imem_fetch_sequencer

Overview:
- Owns the fetch PC and the single port of the 2K-word instruction ROM/RAM. The memory has combinational read, synchronous write, text base 0x0000_3000.
- Sequences pipeline fetch: reset hold, run, stall, redirect and fault.
- Shares the memory port with a program-loader requester that writes instructions while the core is held.
- Sits between the IF stage and the instruction memory.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address and base of the legal window.
- DEPTH_WORDS, 2048, memory depth in words. The legal window is [RESET_PC, RESET_PC + 4*DEPTH_WORDS).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  pulse: IDLE -> RUN
- stall  in  1  hold PC (IF/ID hazard)
- redirect_valid  in  1  branch/jump taken
- redirect_pc  in  32  target address
- ld_req  in  1  loader requests port ownership (level)
- ld_valid  in  1  loader write beat valid
- ld_addr  in  32  byte address of write
- ld_data  in  32  instruction word
- ld_ready  out  1  loader beat accepted this cycle
- ld_err  out  1  1-cycle pulse: beat dropped, out-of-window or misaligned
- imem_addr  out  32  byte address to memory
- imem_we  out  1  memory write enable
- imem_wdata  out  32  memory write data
- pc_out  out  32  PC of the instruction currently on the memory read data
- inst_valid  out  1  memory read data is a valid fetched instruction
- fault  out  1  sticky: fetch PC left the window or was misaligned
- fetch_count  out  32  number of instructions issued since reset

Behaviour:
- Reset, synchronous, active-high:
  - state = IDLE, PC = RESET_PC.
  - inst_valid, imem_we, ld_ready, ld_err and fault = 0.
  - fetch_count = 0.
  - Reset wins over every other input in the same cycle, including mid-load; a beat in flight at reset is not written.
- States: IDLE, RUN, LOAD, FAULT.
- IDLE:
  - inst_valid = 0, imem_addr = PC.
  - ld_req -> LOAD, with priority over start.
  - start -> RUN.
- RUN:
  - imem_addr = PC; inst_valid = 1 combinationally in the cycle PC is presented; pc_out = PC.
  - Each cycle, first match wins:
    - redirect_valid: next PC = redirect_pc. Redirect overrides stall.
    - stall: PC held.
    - otherwise: PC + 4.
  - fetch_count increments on every cycle with inst_valid = 1 and !stall. A redirect cycle counts.
  - ld_req sampled high -> LOAD next cycle. The PC value is irrelevant because the exit path restarts at RESET_PC.
  - Next PC misaligned (bits [1:0] != 0) or outside the window -> FAULT next cycle, PC register captures the bad value.
- LOAD:
  - inst_valid = 0, ld_ready = 1.
  - imem_addr = ld_addr, imem_wdata = ld_data.
  - imem_we = ld_valid & in-window & aligned.
  - A beat with ld_valid high that is out-of-window or misaligned: imem_we = 0, ld_err = 1 the following cycle, and the beat is still consumed (ld_ready = 1).
  - ld_req low -> IDLE next cycle with PC = RESET_PC. Any ld_valid in that final cycle is still written.
- FAULT:
  - fault = 1, inst_valid = 0, PC frozen at the bad value.
  - Only reset exits FAULT; ld_req is ignored and ld_ready = 0.
- Loader outside LOAD: ld_ready = 0, imem_we = 0, beats ignored, no ld_err.
- Window check:
  - In-window means (addr - RESET_PC) < 4*DEPTH_WORDS, computed as a 32-bit unsigned subtract.
  - Addresses below RESET_PC wrap to large values and are therefore out of window.
- PC + 4 wrap at 0xFFFF_FFFC yields 0, which is out of window, so the sequencer enters FAULT.
- fetch_count wraps modulo 2^32.

Test Plan:
- Reset, then start pulse, 4 free cycles -> imem_addr/pc_out = 0x3000, 0x3004, 0x3008, 0x300C; inst_valid = 1 from the first RUN cycle; fetch_count = 4.
- Stall and redirect: stall high for 2 cycles at PC 0x3008 -> PC held, fetch_count unchanged. Then stall and redirect_valid both high with redirect_pc = 0x3040 -> next PC = 0x3040.
- Loader session: ld_req high in RUN; beats 0x3000 <- 0x2408_0001 and 0x3004 <- 0x0000_000C.
  - imem_we = 1 on both beats, inst_valid = 0 throughout.
  - ld_req low -> IDLE, PC = 0x3000.
  - start -> fetch resumes at 0x3000 reading the new data.
- Bad loader beats:
  - ld_addr = 0x2FFC -> no write, ld_err pulse.
  - ld_addr = 0x3002 -> no write, ld_err pulse.
  - ld_addr = 0x3000 + 4*2048 -> no write, ld_err pulse.
- Fault:
  - redirect_pc = 0x3001 -> FAULT, fault = 1, inst_valid = 0; start and ld_req are ignored; reset clears fault.
  - redirect_pc = 0x2000 -> same result.
- Reset mid-load: reset asserted with ld_valid high -> imem_we = 0 that cycle; state IDLE, PC = 0x3000, fetch_count = 0.
